demux1to2_reg: RTL and testbench
================================

Name: demux1to2_reg

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshaking. It is the counterpart of the parameterised 2-to-1 mux in the Teacher-Core IP library.
- One input stream is steered by a select bit to one of two output channels. Each channel has its own single-entry output register.
- Used where one producer (e.g. the ALU result bus) feeds two consumers that can stall independently.

Parameters:
- WIDTH, 8: data width of the input and both output channels.
- CNT_W, 16: width of the per-channel transfer counters. Used only when DEMUX_CNT_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the input word this cycle.
- in_data  input  WIDTH  input word.
- s  input  1  select: 0 routes to channel 0, 1 routes to channel 1.
- q0_valid  output  1  channel 0 holds a word.
- q0_ready  input  1  channel 0 consumer accepts.
- q0  output  WIDTH  channel 0 data.
- q1_valid  output  1  channel 1 holds a word.
- q1_ready  input  1  channel 1 consumer accepts.
- q1  output  WIDTH  channel 1 data.
- (DEMUX_CNT_EN only) cnt_clr  input  1  synchronous clear of both counters.
- (DEMUX_CNT_EN only) cnt0  output  CNT_W  completed channel 0 output handshakes.
- (DEMUX_CNT_EN only) cnt1  output  CNT_W  completed channel 1 output handshakes.

Behaviour:
- Reset values (rst_n low, asynchronous): q0_valid=0, q1_valid=0, q0=0, q1=0, cnt0=0, cnt1=0. in_ready follows from the empty slots, so it equals 1.
- Per-channel slot state is qN_valid: EMPTY when 0, FULL when 1.
- in_ready is combinational:
  - s=0: in_ready = !q0_valid | q0_ready.
  - s=1: in_ready = !q1_valid | q1_ready.
  - in_ready does not depend on in_valid.
- Input handshake: a transfer occurs when in_valid & in_ready at the rising edge. The word is written into qN for N=s, and qN_valid is set.
- Latency: exactly 1 cycle from input handshake to the word appearing on qN with qN_valid=1. There is no combinational path from in_data to qN.
- Output handshake: qN_valid & qN_ready at the edge.
  - If there is no simultaneous input write to the same channel, qN_valid clears.
  - qN keeps its last value after the valid is dropped (no zeroing).
- Simultaneous drain and load on the same channel: the new word is loaded and qN_valid stays 1. The channel sustains full throughput, one word per cycle.
- Independence: the unselected channel is unaffected by the input. A stalled channel (FULL and qN_ready=0) blocks only inputs with s pointing at it. Words already in the other channel continue to drain.
- Stability rules:
  - While qN_valid=1 and qN_ready=0, qN and qN_valid hold.
  - The producer holds in_data and s stable while in_valid=1 and in_ready=0. The block does not check this.
- s and in_data are don't-care while in_valid=0.
- Words are delivered in order within each channel. There is no ordering guarantee between channels.
- Reset asserted mid-operation: buffered words are discarded immediately and all outputs return to reset values. The first edge after rst_n rises may accept a word.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - Ports cnt_clr, cnt0 and cnt1 exist.
  - cntN increments by 1 on each output handshake of channel N and wraps from 2^CNT_W-1 to 0.
  - cnt_clr=1 forces both counters to 0 at the edge. Clear takes priority over a same-cycle increment.
  - Counters are updated one cycle after the handshake edge.
- Undefined: these ports and registers are absent. Datapath behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 mid-run with q0_valid=1 -> q0_valid, q1_valid and q0 read 0 asynchronously; in_ready=1.
- Routing: WIDTH=8, in_data=8'h09, s=0, in_valid=1 for one cycle; both qN_ready=1 -> next cycle q0=8'h09 and q0_valid=1 for one cycle; q1_valid stays 0. Repeat with 8'hB6, s=1 -> q1=8'hB6.
- Backpressure: q0_ready=0, send 8'h09 then 8'h11 to channel 0 ->
  - q0 holds 8'h09 and in_ready=0 while the second word is pending.
  - Raising q0_ready gives 8'h09 then 8'h11 on consecutive cycles with no bubble.
- Independence: channel 0 stalled and FULL; send 8'hB6 with s=1 -> accepted at once; q1=8'hB6 next cycle.
- Throughput: q1_ready=1, stream 8'h00..8'h0F with s=1 on consecutive cycles -> in_ready stays 1 and q1 shows all 16 values in order, 1-cycle delayed.
- Counters (DEMUX_CNT_EN, CNT_W=4): 17 channel 0 transfers -> cnt0 wraps to 1. Assert cnt_clr in the same cycle as a transfer -> cnt0=0.

Source files
------------

// File: rtl/demux1to2_reg_if.sv
// demux1to2_reg_if
// Bundles the input stream and both output channels of demux1to2_reg.
//
// Handshake rule for every channel (in, q0, q1): a word moves on a rising
// clock edge where valid and ready are both 1. A source keeps its word and
// valid stable until that edge. Ready may depend combinationally on the
// sink's own state, but never on the matching valid.
//
// Modports:
//   slave  - the demux itself (receives in_*, drives q0*/q1*)
//   master - the surrounding producer/consumers
//
// Signals:
//   in_valid, in_ready, in_data, s   input stream plus channel select
//   q0_valid, q0_ready, q0           channel 0 output
//   q1_valid, q1_ready, q1           channel 1 output
interface demux1to2_reg_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             s;
  logic             q0_valid;
  logic             q0_ready;
  logic [WIDTH-1:0] q0;
  logic             q1_valid;
  logic             q1_ready;
  logic [WIDTH-1:0] q1;

  modport slave (
    input  in_valid, in_data, s, q0_ready, q1_ready,
    output in_ready, q0_valid, q0, q1_valid, q1
  );

  modport master (
    output in_valid, in_data, s, q0_ready, q1_ready,
    input  in_ready, q0_valid, q0, q1_valid, q1
  );
endinterface

// File: rtl/demux1to2_reg.sv
// demux1to2_reg
// Registered 1-to-2 demultiplexer with valid/ready handshaking. One input
// stream is steered by s to one of two single-entry output registers. Each
// channel drains and stalls independently.
//
// Optional feature (macro DEMUX_CNT_EN): per-channel counters of completed
// output handshakes, with a synchronous clear.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      demux1to2_reg_if.slave (in_*, s, q0*, q1*)
//   cnt_clr  (DEMUX_CNT_EN) synchronous clear of both counters
//   cnt0     (DEMUX_CNT_EN) completed channel 0 output handshakes
//   cnt1     (DEMUX_CNT_EN) completed channel 1 output handshakes
//
// Slot state per channel is its valid flag: 0 = EMPTY, 1 = FULL. The flags
// are visible directly on bus.q0_valid / bus.q1_valid.
module demux1to2_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux1to2_reg_if.slave        bus
`ifdef DEMUX_CNT_EN
  ,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      cnt0,
  output logic [CNT_W-1:0]      cnt1
`endif
);

  // Current slot state and data
  logic             v0_q, v1_q;
  logic [WIDTH-1:0] d0_q, d1_q;

  // Next slot state and data
  logic             v0_n, v1_n;
  logic [WIDTH-1:0] d0_n, d1_n;

  // Handshake terms
  logic in_ready_c;
  logic load0, load1;
  logic drain0, drain1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      d0_q <= '0;
      d1_q <= '0;
    end else begin
      v0_q <= v0_n;
      v1_q <= v1_n;
      d0_q <= d0_n;
      d1_q <= d1_n;
    end
  end

  // Next-state logic. A load wins over a drain on the same channel, so a
  // channel that is drained and reloaded in one cycle stays FULL and passes
  // one word per cycle.
  always_comb begin
    load0  = bus.in_valid & in_ready_c & ~bus.s;
    load1  = bus.in_valid & in_ready_c &  bus.s;
    drain0 = v0_q & bus.q0_ready;
    drain1 = v1_q & bus.q1_ready;

    v0_n = load0 | (v0_q & ~drain0);
    v1_n = load1 | (v1_q & ~drain1);

    // Data only changes on a load; a drained slot keeps its last word.
    d0_n = load0 ? bus.in_data : d0_q;
    d1_n = load1 ? bus.in_data : d1_q;
  end

  // Output logic. in_ready looks only at the selected slot, so a stalled
  // channel never blocks traffic headed for the other one.
  always_comb begin
    in_ready_c   = bus.s ? (~v1_q | bus.q1_ready) : (~v0_q | bus.q0_ready);
    bus.in_ready = in_ready_c;
    bus.q0_valid = v0_q;
    bus.q1_valid = v1_q;
    bus.q0       = d0_q;
    bus.q1       = d1_q;
  end

`ifdef DEMUX_CNT_EN
  // Handshakes are captured first and added on the following edge. A clear
  // also drops a captured handshake, so clearing in the same cycle as a
  // transfer leaves the counter at 0.
  logic hs0_q, hs1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs0_q <= 1'b0;
      hs1_q <= 1'b0;
      cnt0  <= '0;
      cnt1  <= '0;
    end else if (cnt_clr) begin
      hs0_q <= 1'b0;
      hs1_q <= 1'b0;
      cnt0  <= '0;
      cnt1  <= '0;
    end else begin
      hs0_q <= drain0;
      hs1_q <= drain1;
      cnt0  <= cnt0 + CNT_W'(hs0_q);
      cnt1  <= cnt1 + CNT_W'(hs1_q);
    end
  end
`endif

endmodule

// File: tb/tb_demux1to2_reg.sv
// tb_demux1to2_reg
// Self-checking bench for demux1to2_reg. Directed cases for routing,
// backpressure, channel independence, throughput and asynchronous reset,
// then randomized traffic. A negedge monitor keeps one expected queue per
// channel: words are pushed when the input handshake is seen and popped
// when that channel's output handshake is seen. With DEMUX_CNT_EN defined
// the counters are checked with CNT_W=4.
module tb_demux1to2_reg;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux1to2_reg_if #(.WIDTH(WIDTH)) bus ();

`ifdef DEMUX_CNT_EN
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
`endif

  demux1to2_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DEMUX_CNT_EN
    ,
    .cnt_clr (cnt_clr),
    .cnt0    (cnt0),
    .cnt1    (cnt1)
`endif
  );

  // Scoreboard state
  logic [WIDTH-1:0] exp_q0[$];
  logic [WIDTH-1:0] exp_q1[$];
  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Monitor: compare valid flags against the model occupancy, pop on output
  // handshakes, push on input handshakes.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      check("q0_valid", 32'(bus.q0_valid), 32'(exp_q0.size() != 0));
      check("q1_valid", 32'(bus.q1_valid), 32'(exp_q1.size() != 0));
      if (bus.q0_valid && bus.q0_ready && exp_q0.size() != 0)
        check("q0_data", 32'(bus.q0), 32'(exp_q0.pop_front()));
      if (bus.q1_valid && bus.q1_ready && exp_q1.size() != 0)
        check("q1_data", 32'(bus.q1), 32'(exp_q1.pop_front()));
      if (bus.in_valid && bus.in_ready) begin
        if (bus.s) exp_q1.push_back(bus.in_data);
        else       exp_q0.push_back(bus.in_data);
      end
    end
  end

  // Driver tasks. All called at posedge+1; they return at posedge+1.
  task automatic idle_cycles(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one word and hold it until accepted; waits = stall cycles.
  task automatic send(input logic [WIDTH-1:0] d, input logic sel,
                      output int waits);
    bit done;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.s        = sel;
    waits = 0;
    done  = 1'b0;
    while (!done && waits < 200) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      else waits++;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      check("send_timeout", 32'(0), 32'(1));
      bus.in_valid = 1'b0;
    end
  endtask

  int w;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.s        = 1'b0;
    bus.q0_ready = 1'b1;
    bus.q1_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #2;
    check("rst_q0_valid", 32'(bus.q0_valid), 32'(0));
    check("rst_q1_valid", 32'(bus.q1_valid), 32'(0));
    check("rst_q0", 32'(bus.q0), 32'(0));
    check("rst_q1", 32'(bus.q1), 32'(0));
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Routing: one word to each channel
    send(8'h09, 1'b0, w);
    idle_cycles(1);
    check("route_q0_hold", 32'(bus.q0), 32'(8'h09));
    check("route_q0_empty", 32'(bus.q0_valid), 32'(0));
    send(8'hB6, 1'b1, w);
    idle_cycles(2);
    check("route_q1_hold", 32'(bus.q1), 32'(8'hB6));

    // Backpressure on channel 0
    bus.q0_ready = 1'b0;
    send(8'h09, 1'b0, w);
    check("bp_first_wait", 32'(w), 32'(0));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h11;
    bus.s        = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'(0));
      check("bp_q0_hold", 32'(bus.q0), 32'(8'h09));
      @(posedge clk);
      #1;
    end
    bus.q0_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(bus.in_ready), 32'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_second_q0", 32'(bus.q0), 32'(8'h11));
    check("bp_no_bubble", 32'(bus.q0_valid), 32'(1));
    @(posedge clk);
    #1;
    idle_cycles(1);

    // Independence: channel 0 stalled and full, channel 1 still flows
    bus.q0_ready = 1'b0;
    send(8'h5A, 1'b0, w);
    send(8'hB6, 1'b1, w);
    check("indep_wait", 32'(w), 32'(0));
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("indep_q1", 32'(bus.q1), 32'(8'hB6));
    check("indep_q0_hold", 32'(bus.q0), 32'(8'h5A));
    @(posedge clk);
    #1;
    bus.q0_ready = 1'b1;
    idle_cycles(2);

    // Throughput: 16 back-to-back words on channel 1
    for (int i = 0; i < 16; i++) begin
      send(WIDTH'(i), 1'b1, w);
      check("tput_wait", 32'(w), 32'(0));
    end
    idle_cycles(2);

    // Randomized traffic with random consumer stalls
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          @(posedge clk);
          #1;
          bus.q0_ready = ($urandom_range(0, 3) != 0);
          bus.q1_ready = ($urandom_range(0, 2) != 0);
        end
      end
      begin
        for (int i = 0; i < 120; i++) begin
          if ($urandom_range(0, 3) == 0) idle_cycles(1);
          send(WIDTH'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), w);
        end
        bus.in_valid = 1'b0;
      end
    join
    bus.q0_ready = 1'b1;
    bus.q1_ready = 1'b1;
    idle_cycles(3);
    check("drain_q0_empty", 32'(exp_q0.size()), 32'(0));
    check("drain_q1_empty", 32'(exp_q1.size()), 32'(0));

    // Asynchronous reset with channel 0 full
    bus.q0_ready = 1'b0;
    send(8'hC3, 1'b0, w);
    bus.in_valid = 1'b0;
    #2;
    check("pre_rst_q0_valid", 32'(bus.q0_valid), 32'(1));
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_q0_valid", 32'(bus.q0_valid), 32'(0));
    check("arst_q1_valid", 32'(bus.q1_valid), 32'(0));
    check("arst_q0", 32'(bus.q0), 32'(0));
    check("arst_in_ready", 32'(bus.in_ready), 32'(1));
    exp_q0.delete();
    exp_q1.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.q0_ready = 1'b1;
    mon_en = 1'b1;
    send(8'h3C, 1'b0, w);
    check("post_rst_wait", 32'(w), 32'(0));
    idle_cycles(2);

`ifdef DEMUX_CNT_EN
    // Counters: clear, then 17 channel 0 transfers wrap a 4-bit counter to 1
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    idle_cycles(2);
    check("cnt0_cleared", 32'(cnt0), 32'(0));
    check("cnt1_cleared", 32'(cnt1), 32'(0));
    for (int i = 0; i < 17; i++) send(WIDTH'(i), 1'b0, w);
    idle_cycles(3);
    check("cnt0_wrap", 32'(cnt0), 32'(1));
    check("cnt1_idle", 32'(cnt1), 32'(0));
    // Clear coinciding with an output handshake on channel 0
    send(8'h77, 1'b0, w);
    bus.in_valid = 1'b0;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    idle_cycles(2);
    check("cnt0_clr_priority", 32'(cnt0), 32'(0));
`endif

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: run did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
